// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: received-byte bus between the UART receiver and the command parser
interface uart_rx_byte_if #(
    parameter int Word_Length = 8
);
    logic [Word_Length-1:0] Data_Output;
    logic                   data_ready;
    logic                   interrupt;
    logic                   frame_error;
    logic                   parity_error;

    modport master (
        output Data_Output,
        output data_ready,
        output interrupt,
        output frame_error,
        output parity_error
    );

    modport slave (
        input Data_Output,
        input data_ready,
        input interrupt,
        input frame_error,
        input parity_error
    );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampling 8N1/8E1/8O1 serial receiver feeding the command parser byte bus
module uart_rx_byte #(
    parameter int Word_Length  = 8,
    parameter int BAUD_DIVISOR = 5208,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_byte_if.master bus
);
    localparam int CW = $clog2(BAUD_DIVISOR);
    localparam int BW = $clog2(Word_Length + 1);
    localparam logic [CW-1:0] LAST     = CW'(BAUD_DIVISOR - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(BAUD_DIVISOR / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(Word_Length - 1);

    typedef enum logic [2:0] {IDLE, START_CHK, DATA, PARITY, STOP, BREAK} state_t;

    state_t                 state, state_nx;
    logic                   rx_meta, rx_s, armed, perr;
    logic                   tick, mid, stop_smp, ok_fire, pe_fire, fe_fire;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    logic [Word_Length-1:0] shift;

    assign tick = cnt == LAST;
    assign mid  = cnt == HALF_M1;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: start is confirmed at mid-bit, then every bit is sampled one bit time later
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (armed && !rx_s) state_nx = START_CHK;
            START_CHK: if (mid) state_nx = rx_s ? IDLE : DATA;
            DATA:      if (tick && bit_cnt == LAST_BIT) state_nx = PARITY_EN ? PARITY : STOP;
            PARITY:    if (tick) state_nx = STOP;
            STOP:      if (tick) state_nx = rx_s ? IDLE : BREAK;
            BREAK:     if (rx_s) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // outputs: stop-bit verdict, low stop bit beats a parity mismatch
    always_comb begin
        stop_smp      = state == STOP && tick;
        ok_fire       = stop_smp && rx_s && !perr;
        pe_fire       = stop_smp && rx_s && perr;
        fe_fire       = stop_smp && !rx_s;
        bus.interrupt = state inside {DATA, PARITY, STOP};
    end

    // synchroniser, arming, baud/bit counters and data shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            perr    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            armed   <= fe_fire ? 1'b0 : armed | rx_s;
            cnt     <= (state_nx != state || tick) ? '0 : cnt + 1'b1;
            bit_cnt <= state != DATA ? '0 : bit_cnt + BW'(tick);
            if (state == DATA && tick) shift <= {rx_s, shift[Word_Length-1:1]};
            if (state == IDLE) perr <= 1'b0;
            else if (state == PARITY && tick) perr <= ^shift ^ rx_s ^ PARITY_ODD;
        end
    end

    // byte bus: Data_Output only updates on a clean frame, result pulses last one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.Data_Output  <= '0;
            bus.data_ready   <= 1'b0;
            bus.frame_error  <= 1'b0;
            bus.parity_error <= 1'b0;
        end else begin
            if (ok_fire) bus.Data_Output <= shift;
            bus.data_ready   <= ok_fire;
            bus.frame_error  <= fe_fire;
            bus.parity_error <= pe_fire;
        end
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: scoreboard bench for the UART receiver, 8N1 and 8E1 instances
module tb_uart_rx_byte;
    localparam int BD = 16;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] last_good[2];
    int         n_cmp = 0;
    int         n_err = 0;
    int         irq_a = 0;

    uart_rx_byte_if #(.Word_Length(8)) ifa ();
    uart_rx_byte_if #(.Word_Length(8)) ifb ();

    uart_rx_byte #(.Word_Length(8), .BAUD_DIVISOR(BD), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .bus(ifa)
    );

    uart_rx_byte #(.Word_Length(8), .BAUD_DIVISOR(BD), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // kind: 0 = data_ready, 1 = frame_error, 2 = parity_error
    task automatic mon(input int id, input logic dr, input logic fe, input logic pe,
                       input logic irq, input logic [7:0] d);
        exp_t e;
        int   k;
        bit   have;
        if (!(dr || fe || pe)) return;
        k = dr ? 0 : fe ? 1 : 2;
        chk(id == 0 ? "one_pulse_a" : "one_pulse_b", int'(dr) + int'(fe) + int'(pe), 1);
        chk(id == 0 ? "irq_low_on_pulse_a" : "irq_low_on_pulse_b", irq, 0);
        have = id == 0 ? qa.size() != 0 : qb.size() != 0;
        if (!have) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pulse dut%0d: actual kind %0d data %0h required none", id, k, d);
        end else begin
            e = id == 0 ? qa.pop_front() : qb.pop_front();
            chk(id == 0 ? "kind_a" : "kind_b", k, e.kind);
            chk(id == 0 ? "data_a" : "data_b", d, e.data);
        end
    endtask

    always @(negedge clk) mon(0, ifa.data_ready, ifa.frame_error, ifa.parity_error, ifa.interrupt, ifa.Data_Output);
    always @(negedge clk) mon(1, ifb.data_ready, ifb.frame_error, ifb.parity_error, ifb.interrupt, ifb.Data_Output);
    always @(negedge clk) if (ifa.interrupt) irq_a++;

    task automatic hold(input int id, input logic v, input int n);
        if (id == 0) rx_a = v;
        else rx_b = v;
        repeat (n) @(negedge clk);
    endtask

    // reference model: the outcome of a frame follows from its stop bit and parity count alone
    task automatic send(input int id, input logic [7:0] b, input bit par_ok, input bit stop);
        exp_t e;
        logic pbit;
        pbit = (($countones(b) % 2) == 1) ^ !par_ok;
        if (!stop) e = '{1, last_good[id]};
        else if (id == 1 && !par_ok) e = '{2, last_good[id]};
        else begin
            e = '{0, b};
            last_good[id] = b;
        end
        if (id == 0) qa.push_back(e);
        else qb.push_back(e);
        hold(id, 1'b0, BD);
        for (int i = 0; i < 8; i++) hold(id, b[i], BD);
        if (id == 1) hold(id, pbit, BD);
        hold(id, stop, BD);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] stream[4];
        int         n, snap;
        bit         st;
        stream = '{8'hFE, 8'h03, 8'h00, 8'hEF};
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_data_a", ifa.Data_Output, 0);
        chk("rst_dr_a", ifa.data_ready, 0);
        chk("rst_irq_a", ifa.interrupt, 0);
        chk("rst_fe_a", ifa.frame_error, 0);
        chk("rst_pe_a", ifa.parity_error, 0);
        chk("rst_data_b", ifb.Data_Output, 0);
        chk("rst_dr_b", ifb.data_ready, 0);
        chk("rst_irq_b", ifb.interrupt, 0);
        chk("rst_fe_b", ifb.frame_error, 0);
        chk("rst_pe_b", ifb.parity_error, 0);
        reset = 1'b1;
        repeat (8) @(negedge clk);

        // first byte 0xFE with interrupt rise latency
        fork
            send(0, 8'hFE, 1'b1, 1'b1);
            begin
                n = 0;
                while (!ifa.interrupt && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                chk("irq_rise_window", n >= 8 && n <= 14, 1);
            end
        join
        hold(0, 1'b1, BD);

        // short glitch on the line is rejected
        snap = irq_a;
        hold(0, 1'b0, 3);
        hold(0, 1'b1, 40);
        chk("glitch_no_irq", irq_a - snap, 0);

        // low stop bit then a long break, then a clean byte
        send(0, 8'h55, 1'b1, 1'b0);
        hold(0, 1'b0, 40);
        hold(0, 1'b1, BD);
        chk("hold_after_fe", ifa.Data_Output, 8'hFE);
        send(0, 8'h12, 1'b1, 1'b1);
        hold(0, 1'b1, BD);

        // even parity good and bad
        send(1, 8'h03, 1'b1, 1'b1);
        hold(1, 1'b1, 4);
        send(1, 8'h03, 1'b0, 1'b1);
        hold(1, 1'b1, BD);

        // zero-idle streaming
        foreach (stream[i]) send(0, stream[i], 1'b1, 1'b1);
        hold(0, 1'b1, BD);

        // random frames with random gaps, errors and parity on both instances
        for (int i = 0; i < 16; i++) begin
            st = $urandom_range(0, 5) != 0;
            send(1, 8'($urandom), $urandom_range(0, 4) != 0, st);
            hold(1, 1'b1, st ? $urandom_range(0, 20) : BD);
        end
        for (int i = 0; i < 8; i++) begin
            st = $urandom_range(0, 5) != 0;
            send(0, 8'($urandom), 1'b1, st);
            hold(0, 1'b1, st ? $urandom_range(0, 20) : BD);
        end
        hold(0, 1'b1, BD);
        hold(1, 1'b1, BD);

        // reset in the middle of a frame with the line held low
        hold(0, 1'b0, 40);
        reset = 1'b0;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        repeat (3) @(negedge clk);
        chk("midrst_data_a", ifa.Data_Output, 0);
        chk("midrst_irq_a", ifa.interrupt, 0);
        chk("midrst_data_b", ifb.Data_Output, 0);
        reset = 1'b1;
        snap = irq_a;
        hold(0, 1'b0, 50);
        chk("low_after_rst_no_irq", irq_a - snap, 0);
        chk("low_after_rst_data", ifa.Data_Output, 0);
        hold(0, 1'b1, 2 * BD);
        send(0, 8'hA5, 1'b1, 1'b1);
        hold(0, 1'b1, 2 * BD);

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drained_a", qa.size(), 0);
        chk("drained_b", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
